// File: rtl/spi_sched_pkg.sv
// Shared types and defaults for the SPI bus scheduler.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT_AMP = 3'd1,
    ST_GRANT_ADC = 3'd2,
    ST_GRANT_DAC = 3'd3,
    ST_GUARD     = 3'd4
  } state_t;

  localparam int unsigned CLI_AMP = 0;
  localparam int unsigned CLI_ADC = 1;
  localparam int unsigned CLI_DAC = 2;

  localparam int unsigned AMP_SLOT_DEF     = 10;
  localparam int unsigned ADC_SLOT_DEF     = 35;
  localparam int unsigned DAC_SLOT_DEF     = 34;
  localparam int unsigned GUARD_CYCLES_DEF = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_slot_timer.sv
// Loadable down-counter; o_expire_c flags the final cycle of a loaded interval.
module sched_slot_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire_c = (r_count == W'(1));

endmodule

// File: rtl/spi_bus_scheduler.sv
// Time-bounded one-hot SPI bus arbiter for AMP/ADC/DAC clients with guard gaps.
// Optional SPI_SCHED_AUTO_CYCLE_EN: boot AMP grant, then free-running ADC/DAC alternation.
module spi_bus_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned AMP_SLOT     = AMP_SLOT_DEF,
  parameter int unsigned ADC_SLOT     = ADC_SLOT_DEF,
  parameter int unsigned DAC_SLOT     = DAC_SLOT_DEF,
  parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic amp_req,
  input  logic adc_req,
  input  logic dac_req,
  input  logic amp_done,
  input  logic adc_done,
  input  logic dac_done,
  output logic amp_grant,
  output logic adc_grant,
  output logic dac_grant,
  output logic busy,
  output logic timeout_err,
  output logic spi_ss_b,
  output logic sf_ce0,
  output logic fpga_init_b
);

  localparam int unsigned CNT_MAX = max2(max2(AMP_SLOT, ADC_SLOT), max2(DAC_SLOT, GUARD_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  logic [1:0]       r_last_served;
  logic             r_amp_grant;
  logic             r_adc_grant;
  logic             r_dac_grant;
  logic             r_busy;
  logic             r_timeout_err;

  logic             w_amp_req;
  logic             w_adc_req;
  logic             w_dac_req;
  logic             w_pick_adc;
  logic             w_pick_dac;
  logic             w_in_grant;
  logic             w_done_cur;
  logic             w_grant_end;
  logic             w_expire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

`ifdef SPI_SCHED_AUTO_CYCLE_EN
  // One forced AMP grant after reset, then ADC/DAC always "requesting".
  logic r_amp_boot;
  logic w_unused_reqs;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_amp_boot <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      r_amp_boot <= 1'b0;
    end
  end

  assign w_amp_req     = amp_req | r_amp_boot;
  assign w_adc_req     = 1'b1;
  assign w_dac_req     = 1'b1;
  assign w_unused_reqs = adc_req ^ dac_req;
`else
  assign w_amp_req = amp_req;
  assign w_adc_req = adc_req;
  assign w_dac_req = dac_req;
`endif

  // AMP has fixed priority; ADC/DAC tie goes to whoever was not served last.
  assign w_pick_adc = w_adc_req & (~w_dac_req | (r_last_served == 2'(CLI_DAC)));
  assign w_pick_dac = w_dac_req & ~w_pick_adc;

  assign w_in_grant  = (r_state == ST_GRANT_AMP) | (r_state == ST_GRANT_ADC) |
                       (r_state == ST_GRANT_DAC);
  assign w_done_cur  = ((r_state == ST_GRANT_AMP) & amp_done) |
                       ((r_state == ST_GRANT_ADC) & adc_done) |
                       ((r_state == ST_GRANT_DAC) & dac_done);
  assign w_grant_end = w_in_grant & (w_done_cur | w_expire);

  // Single timer serves both slot limits and the guard interval.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (r_state == ST_IDLE) begin
      if (w_amp_req) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(AMP_SLOT);
      end else if (w_pick_adc) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(ADC_SLOT);
      end else if (w_pick_dac) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(DAC_SLOT);
      end
    end else if (w_grant_end) begin
      w_load     = 1'b1;
      w_load_val = CNT_W'(GUARD_CYCLES);
    end
  end

  sched_slot_timer #(
    .W (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_served <= 2'(CLI_DAC);
      r_amp_grant   <= 1'b0;
      r_adc_grant   <= 1'b0;
      r_dac_grant   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_amp_req) begin
            r_state     <= ST_GRANT_AMP;
            r_amp_grant <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_pick_adc) begin
            r_state     <= ST_GRANT_ADC;
            r_adc_grant <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_pick_dac) begin
            r_state     <= ST_GRANT_DAC;
            r_dac_grant <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_GRANT_AMP, ST_GRANT_ADC, ST_GRANT_DAC: begin
          if (w_grant_end) begin
            r_state       <= ST_GUARD;
            r_amp_grant   <= 1'b0;
            r_adc_grant   <= 1'b0;
            r_dac_grant   <= 1'b0;
            r_timeout_err <= ~w_done_cur;
            if (r_state == ST_GRANT_ADC) r_last_served <= 2'(CLI_ADC);
            if (r_state == ST_GRANT_DAC) r_last_served <= 2'(CLI_DAC);
          end
        end
        ST_GUARD: begin
          if (w_expire) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_amp_grant <= 1'b0;
          r_adc_grant <= 1'b0;
          r_dac_grant <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign amp_grant   = r_amp_grant;
  assign adc_grant   = r_adc_grant;
  assign dac_grant   = r_dac_grant;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign spi_ss_b    = 1'b1;
  assign sf_ce0      = 1'b1;
  assign fpga_init_b = 1'b0;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Scoreboard bench for spi_bus_scheduler: a request-level model predicts each grant
// (client, length, timeout, gap, guard); a monitor measures grants and compares.
module tb_spi_bus_scheduler;
  import spi_sched_pkg::*;

  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req   = 3'b000;
  logic [2:0] done  = 3'b000;
  logic amp_grant, adc_grant, dac_grant, busy, timeout_err, spi_ss_b, sf_ce0, fpga_init_b;

  spi_bus_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .amp_req     (req[0]),
    .adc_req     (req[1]),
    .dac_req     (req[2]),
    .amp_done    (done[0]),
    .adc_done    (done[1]),
    .dac_done    (done[2]),
    .amp_grant   (amp_grant),
    .adc_grant   (adc_grant),
    .dac_grant   (dac_grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .spi_ss_b    (spi_ss_b),
    .sf_ce0      (sf_ce0),
    .fpga_init_b (fpga_init_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cli;
    int len;
    int to;
    int gap;
    int guard;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   plan_d[3];
  bit   late_amp = 1'b0;
  int   last_srv = 2;
  int   mon_phase = 0;

  function automatic int slot_of(input int c);
    return (c == 0) ? 10 : (c == 1) ? 35 : 34;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Expected grant for a client whose engine would finish at grant cycle d.
  task automatic push_grant(input int c, input int d, input int gap);
    exp_t e;
    e.cli   = c;
    e.len   = (d <= slot_of(c)) ? d : slot_of(c);
    e.to    = (d > slot_of(c)) ? 1 : 0;
    e.gap   = gap;
    e.guard = G;
    sbq.push_back(e);
    if (c != 0) last_srv = c;
  endtask

  // Order of service for a set of simultaneous requests (plus optional late AMP).
  task automatic model_batch(input logic [2:0] s, input bit late);
    int order[$];
    int first;
    first = -1;
    if (s[0]) order.push_back(0);
    if (s[1] && s[2]) first = (last_srv == 2) ? 1 : 2;
    else if (s[1]) first = 1;
    else if (s[2]) first = 2;
    if (first >= 0) begin
      order.push_back(first);
      if (late) order.push_back(0);
      if (s[1] && s[2]) order.push_back(3 - first);
    end
    foreach (order[k]) push_grant(order[k], plan_d[order[k]], (k == 0) ? -1 : G + 1);
  endtask

  task automatic finalize(input int cli, input int len, input int to_o, input int gap,
                          input int guard, input bit bf);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", sbq.size(), 1);
    end else begin
      e = sbq.pop_front();
      chk("client", cli, e.cli);
      chk("grant_len", len, e.len);
      chk("timeout", to_o, e.to);
      if (e.gap >= 0) chk("gap", gap, e.gap);
      chk("guard", guard, e.guard);
      chk("grant_clean", int'(bf), 0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || mon_phase != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0 || mon_phase != 0) begin
      chk("drain_timeout", sbq.size() + mon_phase, 0);
      sbq.delete();
      req = 3'b000;
    end
  endtask

  task automatic run_batch(input logic [2:0] s, input int d0, input int d1, input int d2,
                           input bit late);
    plan_d[0] = d0;
    plan_d[1] = d1;
    plan_d[2] = d2;
    late_amp  = late;
    model_batch(s, late);
    @(negedge clock);
    req = req | s;
    wait_drain(400);
  endtask

  // Client engines: drop request on grant, pulse done at planned cycle, stray dones from others.
  initial begin : agent
    int gcnt;
    int idx;
    logic [2:0] g;
    gcnt = 0;
    forever begin
      @(negedge clock);
      done = 3'b000;
      g = {dac_grant, adc_grant, amp_grant};
      if (g != 3'b000) begin
        idx = g[0] ? 0 : (g[1] ? 1 : 2);
        if (gcnt == 0) req[idx] = 1'b0;
        gcnt++;
        if (gcnt == plan_d[idx]) done[idx] = 1'b1;
        for (int j = 0; j < 3; j++)
          if (j != idx && $urandom_range(0, 7) == 0) done[j] = 1'b1;
        if (late_amp && idx != 0 && gcnt == 3) begin
          req[0]   = 1'b1;
          late_amp = 1'b0;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  initial begin : monitor
    int cur, len, gap, since, guard, to_obs;
    bit badf;
    logic [2:0] g;
    cur = 0; len = 0; gap = 0; since = 0; guard = 0; to_obs = 0; badf = 1'b0;
    forever begin
      @(negedge clock);
      g = {dac_grant, adc_grant, amp_grant};
      case (mon_phase)
        0: begin
          if (g != 3'b000) begin
            cur  = g[0] ? 0 : (g[1] ? 1 : 2);
            len  = 1;
            gap  = since;
            badf = (busy !== 1'b1) || (timeout_err !== 1'b0) || ($countones(g) != 1);
            mon_phase = 1;
          end else begin
            since++;
            if (timeout_err !== 1'b0) chk("stray_timeout", int'(timeout_err), 0);
          end
        end
        1: begin
          if (g != 3'b000) begin
            len++;
            if (g != (3'b001 << cur) || busy !== 1'b1 || timeout_err !== 1'b0) badf = 1'b1;
          end else begin
            to_obs = int'(timeout_err);
            since  = 1;
            if (busy === 1'b1) begin
              guard = 1;
              mon_phase = 2;
            end else begin
              finalize(cur, len, to_obs, gap, 0, badf);
              mon_phase = 0;
            end
          end
        end
        default: begin
          since++;
          if (busy === 1'b1) begin
            guard++;
            if (g != 3'b000 || timeout_err !== 1'b0) badf = 1'b1;
          end else begin
            finalize(cur, len, to_obs, gap, guard, badf);
            mon_phase = 0;
          end
        end
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    plan_d[0] = 999; plan_d[1] = 999; plan_d[2] = 999;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_amp_grant", int'(amp_grant), 0);
    chk("rst_adc_grant", int'(adc_grant), 0);
    chk("rst_dac_grant", int'(dac_grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    chk("spi_ss_b", int'(spi_ss_b), 1);
    chk("sf_ce0", int'(sf_ce0), 1);
    chk("fpga_init_b", int'(fpga_init_b), 0);
    reset = 1'b0;
    last_srv = 2;

`ifdef SPI_SCHED_AUTO_CYCLE_EN
    push_grant(0, 999, -1);
    push_grant(1, 999, G + 1);
    push_grant(2, 999, G + 1);
    push_grant(1, 999, G + 1);
    push_grant(2, 999, G + 1);
    wait_drain(800);
`else
    // Directed: ties straight after reset, AMP done at cycle 8, DAC timeout, late AMP, ADC boundary.
    run_batch(3'b110, 999, 5, 7, 1'b0);
    run_batch(3'b110, 999, 6, 4, 1'b0);
    run_batch(3'b001, 8, 999, 999, 1'b0);
    run_batch(3'b100, 999, 999, 999, 1'b0);
    run_batch(3'b110, 4, 12, 9, 1'b1);
    run_batch(3'b010, 999, 35, 999, 1'b0);
    run_batch(3'b010, 999, 3, 999, 1'b0);

    // Reset at ADC grant cycle 20: grant drops, no timeout, next tie goes to ADC.
    plan_d[1] = 999;
    begin
      exp_t e;
      e.cli = 1; e.len = 20; e.to = 0; e.gap = -1; e.guard = 0;
      sbq.push_back(e);
    end
    @(negedge clock);
    req[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 20; i++) begin
      @(negedge clock);
      if (adc_grant === 1'b1) cnt++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    req = 3'b000;
    last_srv = 2;
    wait_drain(50);
    run_batch(3'b110, 999, 2, 2, 1'b0);

    for (int b = 0; b < 30; b++) begin
      logic [2:0] s;
      bit late;
      int d0, d1, d2;
      s    = 3'($urandom_range(1, 7));
      late = !s[0] && ($urandom_range(0, 2) == 0);
      d0   = $urandom_range(1, 13);
      d1   = $urandom_range(1, 38);
      d2   = $urandom_range(1, 37);
      if (late && d1 < 3) d1 = 3;
      if (late && d2 < 3) d2 = 3;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_batch(s, d0, d1, d2, late);
    end
`endif

    chk("sb_leftover", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
